// File: rtl/prog_loader_pkg.sv
// Shared types and defaults for the SPI program-memory loader.
package prog_loader_pkg;
  localparam int PL_ADDR_W = 10;
  localparam int PL_DATA_W = 8;

  localparam logic [7:0] CMD_WRITE_DEF = 8'hA5;
  localparam logic [7:0] CMD_READ_DEF  = 8'h5A;

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR_H, ADDR_L, WRITE, READ, IGNORE
  } state_t;
endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronisers for the SPI pins plus single-clk edge pulses.
module spi_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic sck,
  input  logic mosi,
  input  logic cs_n,
  output logic mosi_s,
  output logic cs_n_s,
  output logic sck_rise,
  output logic sck_fall,
  output logic cs_fall
);
  // [1] is the synced value, [2] its previous sample for edge detection
  logic [2:0] sck_q;
  logic [1:0] mosi_q;
  logic [2:0] cs_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sck_q  <= 3'b000;
      mosi_q <= 2'b00;
      cs_q   <= 3'b111;
    end else begin
      sck_q  <= {sck_q[1:0], sck};
      mosi_q <= {mosi_q[0], mosi};
      cs_q   <= {cs_q[1:0], cs_n};
    end
  end

  assign mosi_s   = mosi_q[1];
  assign cs_n_s   = cs_q[1];
  assign sck_rise =  sck_q[1] & ~sck_q[2];
  assign sck_fall = ~sck_q[1] &  sck_q[2];
  assign cs_fall  = ~cs_q[1]  &  cs_q[2];
endmodule

// File: rtl/prog_rom_loader.sv
// Program RAM for CPU fetch, loadable/readable over an SPI mode-0 slave;
// holds the CPU in reset during and shortly after a load.
module prog_rom_loader
  import prog_loader_pkg::*;
#(
  parameter int          ADDR_W    = PL_ADDR_W,
  parameter int          DATA_W    = PL_DATA_W,
  parameter int          RST_HOLD  = 4,
  parameter logic [7:0]  CMD_WRITE = CMD_WRITE_DEF,
  parameter logic [7:0]  CMD_READ  = CMD_READ_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr_bus,
  output logic [DATA_W-1:0] data_bus,
  input  logic              sck,
  input  logic              mosi,
  input  logic              cs_n,
  output logic              miso,
  output logic              cpu_rst,
  output logic              loading,
  output logic              cmd_err
);
  localparam int DEPTH = 2**ADDR_W;
  localparam int BW    = $clog2(DATA_W);
  localparam int HW    = $clog2(RST_HOLD + 1);

  logic mosi_s, cs_n_s, sck_rise, sck_fall, cs_fall;

  spi_sync_edge u_sync (
    .clk      (clk),
    .rst      (rst),
    .sck      (sck),
    .mosi     (mosi),
    .cs_n     (cs_n),
    .mosi_s   (mosi_s),
    .cs_n_s   (cs_n_s),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall),
    .cs_fall  (cs_fall)
  );

  logic [DATA_W-1:0] mem [DEPTH];

  logic [BW-1:0]     bit_cnt;
  logic [DATA_W-2:0] rx_shift;
  logic [DATA_W-1:0] rx_byte;
  logic              byte_done;

  state_t            state, nxt;
  logic [ADDR_W-1:0] addr, addr_nxt, addr_lo, addr_inc;
  logic [DATA_W-1:0] tx_shift, tx_nxt;
  logic              wr_mode, wr_nxt, err_nxt, mem_we;
  logic [HW-1:0]     hold_cnt;

  assign rx_byte   = {rx_shift, mosi_s};
  assign byte_done = sck_rise && !cs_n_s && (bit_cnt == BW'(DATA_W-1));
  assign addr_lo   = {addr[ADDR_W-1:8], rx_byte};
  assign addr_inc  = addr + ADDR_W'(1);

  assign data_bus = mem[addr_bus];
  assign loading  = (state != IDLE);
  assign miso     = (state == READ) && tx_shift[DATA_W-1];

  // Deasserted chip select flushes any partial byte.
  always_ff @(posedge clk) begin
    if (rst || cs_n_s) begin
      bit_cnt  <= '0;
      rx_shift <= '0;
    end else if (sck_rise) begin
      bit_cnt  <= bit_cnt + BW'(1);
      rx_shift <= rx_byte[DATA_W-2:0];
    end
  end

  always_comb begin
    nxt      = state;
    addr_nxt = addr;
    tx_nxt   = tx_shift;
    wr_nxt   = wr_mode;
    err_nxt  = cmd_err;
    mem_we   = 1'b0;
    if (cs_n_s) begin
      nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (cs_fall) nxt = CMD;
        CMD: if (byte_done) begin
          if (rx_byte == CMD_WRITE || rx_byte == CMD_READ) begin
            nxt    = ADDR_H;
            wr_nxt = (rx_byte == CMD_WRITE);
          end else begin
            nxt     = IGNORE;
            err_nxt = 1'b1;
          end
        end
        ADDR_H: if (byte_done) begin
          nxt      = ADDR_L;
          addr_nxt = ADDR_W'({rx_byte, 8'h00});
        end
        ADDR_L: if (byte_done) begin
          addr_nxt = addr_lo;
          if (wr_mode) nxt = WRITE;
          else begin
            nxt    = READ;
            tx_nxt = mem[addr_lo];
          end
        end
        WRITE: if (byte_done) begin
          mem_we   = 1'b1;
          addr_nxt = addr_inc;
        end
        // The fall right after a byte boundary (count 0) must not shift:
        // the freshly loaded MSB is what the host samples next.
        READ: begin
          if (byte_done) begin
            addr_nxt = addr_inc;
            tx_nxt   = mem[addr_inc];
          end else if (sck_fall && bit_cnt != '0) begin
            tx_nxt = {tx_shift[DATA_W-2:0], 1'b0};
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      addr     <= '0;
      tx_shift <= '0;
      wr_mode  <= 1'b0;
      cmd_err  <= 1'b0;
    end else begin
      state    <= nxt;
      addr     <= addr_nxt;
      tx_shift <= tx_nxt;
      wr_mode  <= wr_nxt;
      cmd_err  <= err_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[addr] <= rx_byte;
  end

  // Hold counter reloads while active, then counts down RST_HOLD clks.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= HW'(RST_HOLD);
      cpu_rst  <= 1'b1;
    end else if (nxt != IDLE) begin
      hold_cnt <= HW'(RST_HOLD);
      cpu_rst  <= 1'b1;
    end else if (hold_cnt != '0) begin
      hold_cnt <= hold_cnt - HW'(1);
      cpu_rst  <= 1'b1;
    end else begin
      cpu_rst  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_prog_rom_loader.sv
// Self-checking bench: SPI host model driving bursts, checked against a byte-array memory model.
module tb_prog_rom_loader;
  localparam int HALF = 8;

  logic       clk = 0, rst = 1;
  logic [9:0] addr_bus = '0;
  logic [7:0] data_bus;
  logic       sck = 0, mosi = 0, cs_n = 1;
  logic       miso, cpu_rst, loading, cmd_err;

  int n_cmp = 0, n_err = 0;
  logic [7:0] ref_mem [1024];

  prog_rom_loader dut (
    .clk(clk), .rst(rst), .addr_bus(addr_bus), .data_bus(data_bus),
    .sck(sck), .mosi(mosi), .cs_n(cs_n), .miso(miso),
    .cpu_rst(cpu_rst), .loading(loading), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int nb, output logic [7:0] rx);
    rx = '0;
    for (int i = 7; i > 7 - nb; i--) begin
      mosi = tx[i];
      clks(HALF);
      rx[i] = miso;
      sck = 1;
      clks(HALF);
      sck = 0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    spi_bits(tx, 8, rx);
  endtask

  task automatic spi_start();
    cs_n = 0;
    clks(HALF);
  endtask

  task automatic spi_end();
    clks(HALF);
    cs_n = 1;
    clks(HALF + 4);
  endtask

  task automatic write_burst(input int a, input logic [7:0] d [$]);
    logic [7:0] rx;
    spi_start();
    spi_byte(8'hA5, rx);
    spi_byte(8'(a >> 8), rx);
    spi_byte(8'(a), rx);
    foreach (d[i]) begin
      spi_byte(d[i], rx);
      ref_mem[(a + i) % 1024] = d[i];
    end
    spi_end();
  endtask

  task automatic read_burst(input int a, input int n, output logic [7:0] q [$]);
    logic [7:0] rx;
    q = {};
    spi_start();
    spi_byte(8'h5A, rx);
    spi_byte(8'(a >> 8), rx);
    spi_byte(8'(a), rx);
    for (int i = 0; i < n; i++) begin
      spi_byte(8'h00, rx);
      q.push_back(rx);
    end
    spi_end();
  endtask

  task automatic test_reset();
    int hi;
    rst = 1;
    clks(3);
    n_cmp++;
    if ({cpu_rst, loading, cmd_err, miso} !== 4'b1000) begin
      n_err++;
      $display("FAIL reset_state: got cpu_rst/loading/cmd_err/miso=%b expected 1000",
               {cpu_rst, loading, cmd_err, miso});
    end
    rst = 0;
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cpu_rst === 1'b1) hi++;
      else break;
    end
    n_cmp++;
    if (hi != 4) begin
      n_err++;
      $display("FAIL reset_hold: cpu_rst high %0d clks, expected 4", hi);
    end
  endtask

  task automatic test_write_burst();
    logic [7:0] rx;
    logic [7:0] d [$] = '{8'h3D, 8'h81};
    int hi, w;
    spi_start();
    n_cmp++;
    if ({loading, cpu_rst} !== 2'b11) begin
      n_err++;
      $display("FAIL wr_active: got loading/cpu_rst=%b expected 11", {loading, cpu_rst});
    end
    spi_byte(8'hA5, rx); spi_byte(8'h00, rx); spi_byte(8'h10, rx);
    foreach (d[i]) begin
      spi_byte(d[i], rx);
      ref_mem[16 + i] = d[i];
    end
    clks(HALF);
    cs_n = 1;
    w = 0;
    while (loading !== 1'b0 && w < 20) begin
      @(negedge clk);
      w++;
    end
    n_cmp++;
    if (loading !== 1'b0) begin
      n_err++;
      $display("FAIL wr_idle_timeout: loading=%b expected 0", loading);
    end
    hi = 0;
    while (cpu_rst === 1'b1 && hi < 20) begin
      hi++;
      @(negedge clk);
    end
    n_cmp++;
    if (hi != 4) begin
      n_err++;
      $display("FAIL wr_hold: cpu_rst high %0d clks after idle, expected 4", hi);
    end
    for (int i = 0; i < 2; i++) begin
      addr_bus = 10'(16 + i);
      #1;
      n_cmp++;
      if (data_bus !== ref_mem[16 + i]) begin
        n_err++;
        $display("FAIL wr_data[%0d]: got %h expected %h", 16 + i, data_bus, ref_mem[16 + i]);
      end
    end
  endtask

  task automatic test_read_back(input int a, input int n, input string nm);
    logic [7:0] q [$];
    read_burst(a, n, q);
    for (int i = 0; i < n; i++) begin
      n_cmp++;
      if (q[i] !== ref_mem[(a + i) % 1024]) begin
        n_err++;
        $display("FAIL %s[%0d]: miso byte %h expected %h", nm, i, q[i], ref_mem[(a + i) % 1024]);
      end
    end
    n_cmp++;
    if (miso !== 1'b0) begin
      n_err++;
      $display("FAIL %s_miso_idle: got %b expected 0", nm, miso);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] d [$] = '{8'hAA, 8'hBB};
    int al [2] = '{1023, 0};
    write_burst(1023, d);
    for (int i = 0; i < 2; i++) begin
      addr_bus = 10'(al[i]);
      #1;
      n_cmp++;
      if (data_bus !== ref_mem[al[i]]) begin
        n_err++;
        $display("FAIL wrap[%0d]: got %h expected %h", al[i], data_bus, ref_mem[al[i]]);
      end
    end
    test_read_back(1023, 2, "wrap_rd");
  endtask

  task automatic test_bad_cmd();
    logic [7:0] rx;
    spi_start();
    spi_byte(8'h77, rx); spi_byte(8'h00, rx); spi_byte(8'h10, rx); spi_byte(8'h55, rx);
    spi_end();
    addr_bus = 10'h010;
    #1;
    n_cmp++;
    if (cmd_err !== 1'b1 || data_bus !== ref_mem[16]) begin
      n_err++;
      $display("FAIL bad_cmd: cmd_err=%b data=%h expected 1/%h", cmd_err, data_bus, ref_mem[16]);
    end
    write_burst(32, '{8'hC3});
    n_cmp++;
    if (cmd_err !== 1'b1) begin
      n_err++;
      $display("FAIL cmd_err_sticky: got %b expected 1", cmd_err);
    end
  endtask

  task automatic test_abort();
    logic [7:0] rx;
    spi_start();
    spi_byte(8'hA5, rx); spi_byte(8'h00, rx); spi_byte(8'h20, rx);
    spi_bits(8'h0F, 5, rx);
    spi_end();
    addr_bus = 10'h020;
    #1;
    n_cmp++;
    if (data_bus !== ref_mem[32] || loading !== 1'b0) begin
      n_err++;
      $display("FAIL abort: data=%h loading=%b expected %h/0", data_bus, loading, ref_mem[32]);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] rx;
    write_burst(48, '{8'h5E});
    spi_start();
    spi_byte(8'hA5, rx); spi_byte(8'h00, rx); spi_byte(8'h30, rx);
    spi_bits(8'hE7, 3, rx);
    rst = 1;
    clks(2);
    n_cmp++;
    if ({loading, cpu_rst} !== 2'b01) begin
      n_err++;
      $display("FAIL rst_mid: loading/cpu_rst=%b expected 01", {loading, cpu_rst});
    end
    cs_n = 1;
    clks(4);
    rst = 0;
    clks(8);
    addr_bus = 10'h030;
    #1;
    n_cmp++;
    if (data_bus !== ref_mem[48] || cmd_err !== 1'b0 || loading !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_after: data=%h cmd_err=%b loading=%b expected %h/0/0",
               data_bus, cmd_err, loading, ref_mem[48]);
    end
    write_burst(48, '{8'h9A, 8'h17});
    test_read_back(48, 2, "rst_mid_rd");
  endtask

  task automatic test_random();
    for (int it = 0; it < 5; it++) begin
      int a, n;
      logic [7:0] d [$];
      a = $urandom_range(1023, 0);
      n = $urandom_range(5, 1);
      d = {};
      for (int i = 0; i < n; i++) d.push_back(8'($urandom));
      write_burst(a, d);
      for (int i = 0; i < n; i++) begin
        addr_bus = 10'((a + i) % 1024);
        #1;
        n_cmp++;
        if (data_bus !== d[i]) begin
          n_err++;
          $display("FAIL rand_fetch[%0d]: got %h expected %h", (a + i) % 1024, data_bus, d[i]);
        end
      end
      test_read_back(a, n, "rand_rd");
    end
  endtask

  initial begin
    test_reset();
    test_write_burst();
    test_read_back(16, 2, "read_back");
    test_wrap();
    test_bad_cmd();
    test_abort();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/prog_rom_loader.md
Name: prog_rom_loader

Overview:
- Program-memory responder on the CPU's instruction-fetch interface: 1024x8 RAM driving `data_bus` from `addr_bus`.
- Also an SPI-slave (mode 0) bootloader, so a host can write and read back program bytes.
- Holds the CPU in reset (`cpu_rst`) while a load transaction is active, and for a fixed time after it ends.
- Sits beside the CPU core at top level, replacing the external ROM.

Parameters:
- ADDR_W, 10, program address width; memory depth = 2**ADDR_W.
- DATA_W, 8, instruction byte width.
- RST_HOLD, 4, clk cycles `cpu_rst` stays high after `cs_n` deasserts or after `rst` falls.
- CMD_WRITE, 8'hA5, SPI command byte for a burst write.
- CMD_READ, 8'h5A, SPI command byte for a burst read.

Ports:
- clk  in  1  system clock (all logic on posedge).
- rst  in  1  reset, synchronous, active-high.
- addr_bus  in  ADDR_W  CPU fetch address.
- data_bus  out  DATA_W  mem[addr_bus], asynchronous read.
- sck  in  1  SPI clock, asynchronous to clk.
- mosi  in  1  SPI data in, MSB first.
- cs_n  in  1  SPI chip select, active-low.
- miso  out  1  SPI data out, MSB first.
- cpu_rst  out  1  reset request to the CPU.
- loading  out  1  high while an SPI transaction is active (state != IDLE).
- cmd_err  out  1  sticky: unknown command byte received.

Behaviour:
- Reset values: `cpu_rst`=1, `loading`=0, `cmd_err`=0, `miso`=0, state=IDLE, bit count=0, hold counter=RST_HOLD. Memory contents are not touched by `rst`.
- `data_bus` is combinational from `addr_bus`, zero latency. The CPU samples it in the same cycle `pc` is presented.

Synchronisation:
- `sck`, `mosi` and `cs_n` each pass through a 2-flop synchroniser.
- sck rise/fall are detected from the synced value, one clk pulse each.
- clk must be at least 4x the sck frequency.

Bit handling:
- On each sck rise with cs_n low: shift mosi into an 8-bit register and increment the bit count.
- On the 8th bit: assert byte_done for one clk and reset the count to 0.

FSM (advances on byte_done):
- IDLE: on synced cs_n falling → CMD.
- CMD:
  - byte==CMD_WRITE → ADDR_H (write mode).
  - byte==CMD_READ → ADDR_H (read mode).
  - Else set `cmd_err` and go to IGNORE.
- ADDR_H: addr[9:8] = byte[1:0]; upper bits ignored. → ADDR_L.
- ADDR_L: addr[7:0] = byte.
  - Write mode → WRITE.
  - Read mode → READ: load tx_shift=mem[addr] and drive `miso`=mem[addr][7] in the next clk.
- WRITE: each byte_done → mem[addr] <= byte in that clk edge, then addr <= addr+1.
- READ:
  - On each sck fall, shift tx_shift left and drive `miso` from its MSB.
  - On each byte_done: addr <= addr+1, reload tx_shift=mem[addr+1], drive its MSB.
- IGNORE: consume bytes, no effect.
- Any state: synced cs_n high → IDLE in the next clk. The bit count clears and any partial byte is discarded (no write).

Boundaries:
- Address wraps 1023→0 in both WRITE and READ.
- `miso`=0 whenever not in READ.

cpu_rst:
- High whenever state != IDLE.
- On return to IDLE (and after `rst`), stays high for RST_HOLD further clks, then drops to 0.
- A new cs_n fall during the hold re-asserts loading, and the hold counter reloads.

Other rules:
- `cmd_err` clears only on `rst`.
- A `rst` mid-transaction aborts to IDLE and discards the partial byte; memory already written is kept.

Decomposition:
- Package prog_loader_pkg:
  - state enum {IDLE, CMD, ADDR_H, ADDR_L, WRITE, READ, IGNORE};
  - CMD_WRITE/CMD_READ defaults;
  - ADDR_W/DATA_W constants.
- Sub-module spi_sync_edge: 2-flop synchroniser for sck/mosi/cs_n, with rise/fall pulses for sck and cs_n.

Test Plan:
- Reset then idle: after `rst` falls, `cpu_rst`=1 for exactly 4 clks then 0; `loading`=0, `cmd_err`=0.
- Write burst: cs_n low, send A5 00 10 3D 81 → mem[0x010]=3D, mem[0x011]=81; `data_bus`=3D when `addr_bus`=0x010; `cpu_rst` high throughout, and for 4 clks after cs_n high.
- Read-back: after the write burst, send 5A 00 10 then 16 dummy clocks → `miso` yields 3D then 81, MSB first.
- Wrap: write A5 03 FF AA BB → mem[0x3FF]=AA, mem[0x000]=BB.
- Bad command and abort:
  - Send 77 → `cmd_err`=1 stays set; following bytes write nothing.
  - Separately, A5 00 20 then 5 bits then cs_n high → mem[0x020] unchanged; state IDLE.
- Reset mid-burst: assert `rst` after A5 00 30 and 3 bits → state IDLE, `cpu_rst`=1, memory unchanged, next full transaction works normally.
